// File: rtl/chacha_rng_pkg.sv
// rtl/chacha_rng_pkg.sv - shared constants, request FSM states and word-count helper for the ChaCha RNG reader
package chacha_rng_pkg;

    localparam int BLOCK_W    = 512;
    localparam int GEN_WORD_W = 32;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_e;

    function automatic int WORDS_PER_BLOCK(input int out_w);
        return BLOCK_W / out_w;
    endfunction

endpackage

// File: rtl/chacha_rng_health.sv
// rtl/chacha_rng_health.sv - block-repeat health check; used only when CHACHA_RNG_HEALTH_EN is defined
module chacha_rng_health
    import chacha_rng_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               check_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               accept_o,
    output logic               fail_o
);

    logic [BLOCK_W-1:0] hist_q;
    logic               fail_q;
    logic               repeat_w;

    // history starts at zero, so an all-zero first block is also rejected
    assign repeat_w = (block_i == hist_q);
    assign accept_o = check_i && !repeat_w;
    assign fail_o   = fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fail_q <= 1'b0;
        end else begin
            if (accept_o) begin
                hist_q <= block_i;
            end
            if (check_i && repeat_w) begin
                fail_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/chacha_keystream_reader.sv
// rtl/chacha_keystream_reader.sv - ping-pong keystream buffer and word stream; CHACHA_RNG_HEALTH_EN adds repeat check
module chacha_keystream_reader
    import chacha_rng_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               gen_valid,
    input  logic               gen_intr,
    input  logic [BLOCK_W-1:0] gen_out,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    output logic [OUT_W-1:0]   rnd_data,
    output logic [1:0]         blocks_avail,
    output logic               hc_fail
);

    localparam int               WPB      = WORDS_PER_BLOCK(OUT_W);
    localparam int               IDX_W    = $clog2(WPB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WPB - 1);

    req_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] slot_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         avail_q, avail_d;

    logic               intr_seen;
    logic               accept;
    logic               req_block;
    logic               xfer;
    logic               drain_last;

    // completions outside an outstanding request are not ours to take
    assign intr_seen = (state_q == REQ_WAIT) && gen_intr;

`ifdef CHACHA_RNG_HEALTH_EN
    logic hc_fail_w;

    chacha_rng_health u_health (
        .clk      (clk),
        .rst      (rst),
        .check_i  (intr_seen),
        .block_i  (gen_out),
        .accept_o (accept),
        .fail_o   (hc_fail_w)
    );

    assign req_block = hc_fail_w;
    assign hc_fail   = hc_fail_w;
`else
    assign accept    = intr_seen;
    assign req_block = 1'b0;
    assign hc_fail   = 1'b0;
`endif

    assign xfer         = rnd_valid && rnd_ready;
    assign drain_last   = xfer && (idx_q == IDX_LAST);
    assign rnd_valid    = (avail_q != 2'd0);
    assign rnd_data     = slot_q[rd_ptr_q][OUT_W*idx_q +: OUT_W];
    assign blocks_avail = avail_q;

    always_comb begin
        state_d   = state_q;
        gen_valid = 1'b0;
        case (state_q)
            REQ_IDLE: begin
                if (!rst && !req_block && (avail_q < 2'd2)) begin
                    gen_valid = 1'b1;
                    state_d   = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (gen_intr) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    // a fill and a last-word drain in the same cycle cancel out
    always_comb begin
        avail_d = avail_q;
        if (accept && !drain_last) begin
            avail_d = avail_q + 2'd1;
        end else if (!accept && drain_last) begin
            avail_d = avail_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ_IDLE;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            idx_q     <= '0;
            avail_q   <= 2'd0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            state_q <= state_d;
            avail_q <= avail_d;
            if (accept) begin
                slot_q[wr_ptr_q] <= gen_out;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (xfer) begin
                idx_q <= drain_last ? '0 : idx_q + 1'b1;
                if (drain_last) begin
                    rd_ptr_q <= !rd_ptr_q;
                end
            end
        end
    end

endmodule
